// File: rtl/decode_job_pkg.sv
// Shared types and constants for the decode job sequencer.
// DECODE_JOB_STATS_EN adds the STATS/STATS_TERM states used for the per-job statistics word.
package decode_job_pkg;

    localparam logic [31:0] TERMINATOR   = 32'hFFFF_FFFF;
    localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

    // Statistics word layout: {syndrome_cnt[7:0], latency[23:0]}
    localparam int STATS_CNT_LSB = 24;
    localparam int STATS_LAT_W   = 24;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FORWARD     = 4'd1,
        ST_WAIT_RESULT = 4'd2,
        ST_TAG         = 4'd3,
        ST_RESULT      = 4'd4,
        ST_TO_TAG      = 4'd5,
        ST_TO_CODE     = 4'd6,
        ST_TO_TERM     = 4'd7
`ifdef DECODE_JOB_STATS_EN
        ,
        ST_STATS       = 4'd8,
        ST_STATS_TERM  = 4'd9
`endif
    } state_t;

    function automatic logic [31:0] stats_word(input logic [7:0] cnt, input logic [STATS_LAT_W-1:0] lat);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[STATS_CNT_LSB +: 8]  = cnt;
        w[0 +: STATS_LAT_W]    = lat;
        return w;
    endfunction

endpackage

// File: rtl/decode_job_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register: reset and clear win over increment, increment stops at the maximum.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/decode_job_sequencer.sv
// One-job-at-a-time sequencer between the host word stream and the decoder FIFOs, with timeout recovery.
// Optional macro DECODE_JOB_STATS_EN replaces the forwarded decoder terminator with a stats word plus TERMINATOR.
module decode_job_sequencer
    import decode_job_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] dec_in_data,
    output logic        dec_in_valid,
    input  logic        dec_in_ready,
    input  logic [31:0] dec_out_data,
    input  logic        dec_out_valid,
    output logic        dec_out_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [31:0] job_count,
    output logic [15:0] timeout_count,
    output logic [15:0] stray_count
);

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       job_id_r;
    logic [WAIT_W-1:0] wait_ctr_r;
    logic [31:0]       job_count_r;

    logic job_start_s;
    logic fwd_term_s;
    logic syn_inc_s;
    logic stray_inc_s;
    logic timeout_inc_s;
    logic job_done_s;

`ifdef DECODE_JOB_STATS_EN
    logic        res_hs_s;
    logic        lat_run_r;
    logic [15:0] syndrome_cnt_s;
    logic [23:0] latency_s;
`endif

    // Next-state and stream muxing; reset forces every handshake output inactive.
    always_comb begin
        state_s       = state_r;
        s_ready       = 1'b0;
        dec_in_data   = s_data;
        dec_in_valid  = 1'b0;
        dec_out_ready = 1'b0;
        m_data        = 32'h0000_0000;
        m_valid       = 1'b0;
        job_start_s   = 1'b0;
        fwd_term_s    = 1'b0;
        syn_inc_s     = 1'b0;
        stray_inc_s   = 1'b0;
        timeout_inc_s = 1'b0;
        job_done_s    = 1'b0;
`ifdef DECODE_JOB_STATS_EN
        res_hs_s      = 1'b0;
`endif
        if (reset) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_ready       = 1'b1;
                    dec_out_ready = 1'b1;
                    stray_inc_s   = dec_out_valid;
                    if (s_valid && (s_data != TERMINATOR)) begin
                        job_start_s = 1'b1;
                        state_s     = ST_FORWARD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FORWARD: begin
                    s_ready       = dec_in_ready;
                    dec_in_valid  = s_valid;
                    dec_out_ready = 1'b1;
                    stray_inc_s   = dec_out_valid;
                    if (s_valid && dec_in_ready) begin
                        if (s_data == TERMINATOR) begin
                            fwd_term_s = 1'b1;
                            state_s    = ST_WAIT_RESULT;
                        end else begin
                            syn_inc_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_FORWARD;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (dec_out_valid) begin
                        state_s = ST_TAG;
                    end else if (wait_ctr_r == WAIT_LAST) begin
                        state_s = ST_TO_TAG;
                    end else begin
                        state_s = ST_WAIT_RESULT;
                    end
                end
                ST_TAG: begin
                    m_data  = job_id_r;
                    m_valid = 1'b1;
                    if (m_ready) begin
                        state_s = ST_RESULT;
                    end else begin
                        state_s = ST_TAG;
                    end
                end
                ST_RESULT: begin
`ifdef DECODE_JOB_STATS_EN
                    // The decoder terminator is consumed here and re-emitted after the stats word.
                    if (dec_out_valid && (dec_out_data == TERMINATOR)) begin
                        dec_out_ready = 1'b1;
                        state_s       = ST_STATS;
                    end else begin
                        m_data        = dec_out_data;
                        m_valid       = dec_out_valid;
                        dec_out_ready = m_ready;
                    end
                    res_hs_s = dec_out_valid && dec_out_ready;
`else
                    m_data        = dec_out_data;
                    m_valid       = dec_out_valid;
                    dec_out_ready = m_ready;
                    if (dec_out_valid && m_ready && (dec_out_data == TERMINATOR)) begin
                        job_done_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        state_s = ST_RESULT;
                    end
`endif
                end
                ST_TO_TAG: begin
                    m_data        = job_id_r;
                    m_valid       = 1'b1;
                    dec_out_ready = 1'b1;
                    stray_inc_s   = dec_out_valid;
                    if (m_ready) begin
                        state_s = ST_TO_CODE;
                    end else begin
                        state_s = ST_TO_TAG;
                    end
                end
                ST_TO_CODE: begin
                    m_data        = TIMEOUT_CODE;
                    m_valid       = 1'b1;
                    dec_out_ready = 1'b1;
                    stray_inc_s   = dec_out_valid;
                    if (m_ready) begin
                        state_s = ST_TO_TERM;
                    end else begin
                        state_s = ST_TO_CODE;
                    end
                end
                ST_TO_TERM: begin
                    m_data        = TERMINATOR;
                    m_valid       = 1'b1;
                    dec_out_ready = 1'b1;
                    stray_inc_s   = dec_out_valid;
                    if (m_ready) begin
                        timeout_inc_s = 1'b1;
                        state_s       = ST_IDLE;
                    end else begin
                        state_s = ST_TO_TERM;
                    end
                end
`ifdef DECODE_JOB_STATS_EN
                ST_STATS: begin
                    m_data  = stats_word(syndrome_cnt_s[7:0], latency_s);
                    m_valid = 1'b1;
                    if (m_ready) begin
                        state_s = ST_STATS_TERM;
                    end else begin
                        state_s = ST_STATS;
                    end
                end
                ST_STATS_TERM: begin
                    m_data  = TERMINATOR;
                    m_valid = 1'b1;
                    if (m_ready) begin
                        job_done_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        state_s = ST_STATS_TERM;
                    end
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job ID is captured from the first word of each job and held for the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_id_r <= 32'h0000_0000;
        end else if (job_start_s) begin
            job_id_r <= s_data;
        end else begin
            job_id_r <= job_id_r;
        end
    end

    // Result wait timer, restarted by the forwarded terminator.
    always_ff @(posedge clk) begin
        if (reset || fwd_term_s) begin
            wait_ctr_r <= '0;
        end else if ((state_r == ST_WAIT_RESULT) && !dec_out_valid) begin
            wait_ctr_r <= wait_ctr_r + 1'b1;
        end else begin
            wait_ctr_r <= wait_ctr_r;
        end
    end

    // Completed-job counter, wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_count_r <= 32'h0000_0000;
        end else if (job_done_s) begin
            job_count_r <= job_count_r + 32'd1;
        end else begin
            job_count_r <= job_count_r;
        end
    end

    assign job_count = job_count_r;
    assign busy      = (state_r != ST_IDLE) && !reset;

    sat_counter #(.WIDTH(16)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (timeout_inc_s),
        .count (timeout_count)
    );

    sat_counter #(.WIDTH(16)) u_stray_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (stray_inc_s),
        .count (stray_count)
    );

`ifdef DECODE_JOB_STATS_EN
    // Latency window runs from the forwarded terminator to the first result handshake (inclusive).
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_run_r <= 1'b0;
        end else if (fwd_term_s) begin
            lat_run_r <= 1'b1;
        end else if (res_hs_s) begin
            lat_run_r <= 1'b0;
        end else begin
            lat_run_r <= lat_run_r;
        end
    end

    sat_counter #(.WIDTH(16)) u_syndrome_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (job_start_s),
        .inc   (syn_inc_s),
        .count (syndrome_cnt_s)
    );

    sat_counter #(.WIDTH(24)) u_latency_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (fwd_term_s),
        .inc   (lat_run_r && ((state_r == ST_WAIT_RESULT) || (state_r == ST_TAG) || (state_r == ST_RESULT))),
        .count (latency_s)
    );
`endif

endmodule

// File: tb/tb_decode_job_sequencer.sv
// Scoreboard bench for decode_job_sequencer: expected decoder and host words are queued as stimulus is driven.
module tb_decode_job_sequencer;
    import decode_job_pkg::*;

    localparam int TO_CYC = 16;
`ifdef DECODE_JOB_STATS_EN
    localparam bit STATS_BUILD = 1'b1;
`else
    localparam bit STATS_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] dec_in_data;
    logic        dec_in_valid;
    logic        dec_in_ready = 1'b1;
    logic [31:0] dec_out_data = 32'h0;
    logic        dec_out_valid = 1'b0;
    logic        dec_out_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        busy;
    logic [31:0] job_count;
    logic [15:0] timeout_count;
    logic [15:0] stray_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int term_cyc = 0;
    int last_dout_cyc = 0;
    int last_lat = 0;
    logic [31:0] host_q[$];
    logic [31:0] dec_q[$];
    logic        bp_en = 1'b0;
    logic        mirror_on = 1'b0;
    logic        in_res = 1'b0;
    logic [31:0] mirror_tag = 32'h0;

    decode_job_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .dec_in_data   (dec_in_data),
        .dec_in_valid  (dec_in_valid),
        .dec_in_ready  (dec_in_ready),
        .dec_out_data  (dec_out_data),
        .dec_out_valid (dec_out_valid),
        .dec_out_ready (dec_out_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .job_count     (job_count),
        .timeout_count (timeout_count),
        .stray_count   (stray_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Host ready: steady high, or toggling every cycle while backpressure is enabled.
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? ~m_ready : 1'b1;
    end

    // Monitor sampled mid-cycle: scoreboard pops and RESULT-phase ready mirroring.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mirror_on && in_res && !(STATS_BUILD && dec_out_valid && (dec_out_data == TERMINATOR)))
            check_eq("ready_mirror", {31'b0, dec_out_ready}, {31'b0, m_ready});
        if (!reset && dec_in_valid && dec_in_ready) begin
            check_eq("dec_word_expected", {31'b0, dec_q.size() != 0}, 32'd1);
            if (dec_q.size() != 0) begin
                e = dec_q.pop_front();
                check_eq("dec_word", dec_in_data, e);
            end
            if (dec_in_data == TERMINATOR) term_cyc <= cyc;
        end
        if (!reset && m_valid && m_ready) begin
            check_eq("host_word_expected", {31'b0, host_q.size() != 0}, 32'd1);
            if (host_q.size() != 0) begin
                e = host_q.pop_front();
                check_eq("host_word", m_data, e);
            end
            if (mirror_on && (m_data == mirror_tag)) in_res <= 1'b1;
        end
        if (!reset && dec_out_valid && dec_out_ready) begin
            last_dout_cyc <= cyc;
            if (dec_out_data == TERMINATOR) in_res <= 1'b0;
        end
    end

    task automatic send_host(input logic [31:0] w);
        bit done = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_ready;
        end
        check_eq("host_in_accepted", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_dec(input logic [31:0] w);
        bit done = 1'b0;
        dec_out_data  = w;
        dec_out_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = dec_out_ready;
        end
        check_eq("dec_out_accepted", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        dec_out_valid = 1'b0;
    endtask

    task automatic wait_host_drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (host_q.size() == 0);
        end
        check_eq("host_drained", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [31:0] id, input int nsyn,
                           input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                           input int nres, input logic [31:0] r0, input logic [31:0] r1, input int gap);
        logic [31:0] w;
        host_q.push_back(id);
        send_host(id);
        for (int i = 0; i < nsyn; i++) begin
            w = (i == 0) ? s0 : ((i == 1) ? s1 : s2);
            dec_q.push_back(w);
            send_host(w);
        end
        dec_q.push_back(TERMINATOR);
        send_host(TERMINATOR);
        repeat (gap) @(posedge clk);
        #1;
        for (int i = 0; i < nres; i++) begin
            w = (i == 0) ? r0 : r1;
            host_q.push_back(w);
            send_dec(w);
            if (i == 0) last_lat = last_dout_cyc - term_cyc;
        end
        if (STATS_BUILD) host_q.push_back(stats_word(8'(nsyn), 24'(last_lat)));
        if (!STATS_BUILD) host_q.push_back(TERMINATOR);
        send_dec(TERMINATOR);
        if (STATS_BUILD) host_q.push_back(TERMINATOR);
        wait_host_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check_eq("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("rst_dec_out_ready", {31'b0, dec_out_ready}, 32'd0);
        check_eq("rst_dec_in_valid", {31'b0, dec_in_valid}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_job_count", job_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_s_ready", {31'b0, s_ready}, 32'd1);
        check_eq("idle_dec_out_ready", {31'b0, dec_out_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Normal job
        run_job(32'd7, 2, 32'h0001_0002, 32'h0000_0003, 32'h0, 1, 32'h0005_0012, 32'h0, 0);
        check_eq("normal_job_count", job_count, 32'd1);
        check_eq("normal_busy", {31'b0, busy}, 32'd0);

        // Empty job: a bare terminator is dropped in IDLE
        send_host(TERMINATOR);
        @(negedge clk);
        check_eq("empty_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("empty_busy_later", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Timeout with a silent decoder, then a late stray word
        host_q.push_back(32'h0000_0033);
        send_host(32'h0000_0033);
        dec_q.push_back(32'h0000_0044);
        send_host(32'h0000_0044);
        dec_q.push_back(TERMINATOR);
        host_q.push_back(TIMEOUT_CODE);
        host_q.push_back(TERMINATOR);
        send_host(TERMINATOR);
        repeat (TO_CYC - 1) @(posedge clk);
        @(negedge clk);
        check_eq("to_not_early", {31'b0, m_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("to_tag_valid", {31'b0, m_valid}, 32'd1);
        check_eq("to_tag_data", m_data, 32'h0000_0033);
        wait_host_drain();
        check_eq("timeout_count", {16'b0, timeout_count}, 32'd1);
        check_eq("to_job_count", job_count, 32'd1);
        send_dec(32'h1234_5678);
        check_eq("stray_count", {16'b0, stray_count}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure during RESULT
        mirror_tag = 32'h0000_000B;
        mirror_on  = 1'b1;
        bp_en      = 1'b1;
        run_job(32'h0000_000B, 2, 32'h0000_0101, 32'h0000_0202, 32'h0, 2, 32'h0007_0020, 32'hABCD_0001, 0);
        bp_en      = 1'b0;
        mirror_on  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bp_job_count", job_count, 32'd2);

        // Mid-job reset after one syndrome word
        send_host(32'h0000_0021);
        dec_q.push_back(32'h0000_0055);
        send_host(32'h0000_0055);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("midrst_s_ready", {31'b0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_job_count", job_count, 32'd0);
        check_eq("midrst_timeout_count", {16'b0, timeout_count}, 32'd0);
        check_eq("midrst_stray_count", {16'b0, stray_count}, 32'd0);
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        run_job(32'h0000_0022, 1, 32'h0000_0066, 32'h0, 32'h0, 1, 32'h0003_0004, 32'h0, 1);
        check_eq("post_rst_job_count", job_count, 32'd1);

`ifdef DECODE_JOB_STATS_EN
        // Three syndrome words, first result accepted five cycles after the terminator
        run_job(32'h0000_0009, 3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1, 32'h0005_0012, 32'h0, 2);
        check_eq("stats_word_value", stats_word(8'd3, 24'(last_lat)), 32'h0300_0005);
`endif

        check_eq("dec_q_empty", dec_q.size(), 32'd0);
        check_eq("host_q_empty", host_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_job_sequencer.md
# decode_job_sequencer

Sequences one decode job at a time through the single-FPGA Helios decoder's 32-bit input/output streams. It sits between the host-side word stream and the decoder's input/output FIFOs. It strips and holds the job ID and forwards the syndrome words plus the terminator. It then waits for the decoder's result stream and returns that stream to the host, tagged with the job ID, with timeout recovery when the decoder never answers.

## Interface
- TIMEOUT_CYCLES, 65535: idle cycles allowed while waiting for the first result word.
- TERMINATOR, 32'hFFFFFFFF: end-of-job and end-of-result marker.
- TIMEOUT_CODE, 32'hDEAD0001: error word emitted on timeout.

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_data  in  32  host job stream: job ID, syndrome words, TERMINATOR
- s_valid  in  1  host word valid
- s_ready  out  1  sequencer accepts host word
- dec_in_data  out  32  to decoder input FIFO
- dec_in_valid  out  1
- dec_in_ready  in  1
- dec_out_data  in  32  from decoder output FIFO; first word holds cycles[15:0] and iterations[23:16]
- dec_out_valid  in  1
- dec_out_ready  out  1
- m_data  out  32  host result stream
- m_valid  out  1
- m_ready  in  1
- busy  out  1  state is not IDLE
- job_count  out  32  jobs completed normally
- timeout_count  out  16  jobs aborted by timeout
- stray_count  out  16  decoder words discarded outside a job

## Operation
- **States:** IDLE, FORWARD, WAIT_RESULT, TAG, RESULT, TO_TAG, TO_CODE, TO_TERM.
- **IDLE:** s_ready=1. On a handshake with s_data≠TERMINATOR, latch job_id and go to FORWARD. A TERMINATOR handshake here is an empty job: it is dropped and the state stays IDLE.
- **FORWARD:** combinational pass-through: dec_in_data=s_data, dec_in_valid=s_valid, s_ready=dec_in_ready. On a TERMINATOR handshake, which is forwarded, go to WAIT_RESULT and clear wait_ctr. A syndrome_cnt (16-bit, saturating) counts the non-terminator words.
- **WAIT_RESULT:** dec_out_ready=0.
  - With dec_out_valid=1: go to TAG.
  - Otherwise wait_ctr increments.
  - When wait_ctr==TIMEOUT_CYCLES-1 and dec_out_valid=0: go to TO_TAG.
  - When dec_out_valid and the timeout coincide, dec_out_valid wins.
- **TAG:** m_data=job_id, m_valid=1. On the m_ready handshake go to RESULT.
- **RESULT:** pass-through: m_data=dec_out_data, m_valid=dec_out_valid, dec_out_ready=m_ready. On a TERMINATOR handshake: job_count++ and go to IDLE.
- **Timeout path:** TO_TAG emits job_id, TO_CODE emits TIMEOUT_CODE, TO_TERM emits TERMINATOR. Each state advances on m_ready. Leaving TO_TERM: timeout_count++ and go to IDLE.
- **Stray decoder words:** in IDLE, FORWARD and TO_* states, dec_out_ready=1. Every dec_out handshake there is discarded and increments stray_count; this drains late results.
- **Counters:** job_count wraps. timeout_count and stray_count saturate.

## Timing
- **Reset values:**
  - Outputs: s_ready=0 during reset, dec_in_valid=0, m_valid=0, dec_out_ready=0, busy=0, all counters=0.
  - Internal: state=IDLE.
  - After reset deasserts: s_ready=1 and dec_out_ready=1 (IDLE drain behaviour).
- **Latency:**
  - Forwarding and result pass-through: zero cycles, combinational.
  - Job ID tag: first presented the cycle after WAIT_RESULT sees dec_out_valid.
  - Timeout: the TO_TAG word appears exactly TIMEOUT_CYCLES cycles after the terminator handshake.
- **Handshake rules:**
  - Transfer when valid&&ready.
  - Registered-source outputs (TAG, TO_*) hold data stable until accepted.
  - Backpressure on m_ready propagates to dec_out_ready in RESULT only.
- **Reset mid-job:** returns to IDLE immediately and drops the job without emitting any host words.

## Configuration
DECODE_JOB_STATS_EN:
- **Defined:** RESULT does not forward the decoder TERMINATOR directly. On the TERMINATOR handshake, dec_out_ready is held and the block enters STATS.
  - STATS emits {syndrome_cnt[7:0], latency[23:0]}.
  - latency counts cycles from the FORWARD terminator handshake to the first RESULT handshake, saturating at 24'hFFFFFF.
  - The following state emits TERMINATOR, then the block goes to IDLE.
- **Undefined:** no STATS state, no latency counter. The result stream is a bit-exact pass-through with the tag prepended.

## Structure
- Shared package decode_job_pkg:
  - state enum typedef.
  - TERMINATOR and TIMEOUT_CODE localparams.
  - stats word field offsets.
- One sub-module, sat_counter (parameter WIDTH), used for syndrome_cnt, latency, timeout_count and stray_count.
- All other logic, including the FSM and the muxes, stays in decode_job_sequencer.

## Test plan
- **Normal job:** job 7, words 0x00010002 and 0x00000003, TERMINATOR.
  - Decoder receives exactly those 3 words.
  - Decoder returns 0x00050012, 0xFFFFFFFF.
  - Host sees 0x00000007, 0x00050012, 0xFFFFFFFF; job_count=1.
- **Empty job:** TERMINATOR alone in IDLE → nothing reaches the decoder, busy stays 0.
- **Timeout:** TIMEOUT_CYCLES=16, decoder silent.
  - Host sees job_id, 0xDEAD0001, 0xFFFFFFFF, with the first word 16 cycles after the terminator.
  - timeout_count=1.
  - A late decoder word arriving afterwards increments stray_count to 1 and is never sent to the host.
- **Backpressure:** m_ready toggled every other cycle during RESULT.
  - No word is lost or duplicated.
  - dec_out_ready mirrors m_ready.
- **Mid-job reset:** reset after 1 syndrome word → m_valid=0 and counters=0; the next job proceeds normally.
- **Stats enabled:** with DECODE_JOB_STATS_EN, 3 syndrome words and first decoder word 5 cycles after the terminator → stats word 0x03000005 before TERMINATOR.
